// File: rtl/delay_ram_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : delay_ram_scheduler
// Description : Chorus delay-line RAM sequencer (clkDSP domain). Each dry
//               sample strobe runs a fixed write / read / capture schedule
//               on one single-port RAM and emits the LFO-tapped wet sample
//               with a one-cycle strobe.
// Options     : DELAY_PRIME_MUTE_EN - mute the wet output until the whole
//               buffer has been written once after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_ram_scheduler #(
  parameter int PKT_WIDTH = 16,
  parameter int BUF_DEPTH = 4410,
  parameter int AVG_DELAY = 882,
  localparam int ADDR_W   = $clog2(BUF_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [PKT_WIDTH-1:0] pkt_i,
  input  logic                 pktChanged_i,
  input  logic [PKT_WIDTH-1:0] extraDelay_i,
  output logic [ADDR_W-1:0]    ramAddr_o,
  output logic [PKT_WIDTH-1:0] ramWrData_o,
  output logic                 ramWrEn_o,
  input  logic [PKT_WIDTH-1:0] ramRdData_i,
  output logic [PKT_WIDTH-1:0] pktDelayed_o,
  output logic                 pktDelayedChanged_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_READ    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  // Largest LFO offset that keeps the total delay inside the buffer.
  localparam logic [PKT_WIDTH-1:0] EXTRA_MAX = PKT_WIDTH'(BUF_DEPTH - 1 - AVG_DELAY);
  localparam logic [ADDR_W-1:0]    LAST_SLOT = ADDR_W'(BUF_DEPTH - 1);
  localparam logic [ADDR_W-1:0]    AVG_D     = ADDR_W'(AVG_DELAY);
  localparam logic signed [ADDR_W:0] DEPTH_S = (ADDR_W+1)'(BUF_DEPTH);

  logic [1:0]             state;
  logic [ADDR_W-1:0]      wr_ptr;
  logic [PKT_WIDTH-1:0]   extra_q;
  logic [PKT_WIDTH-1:0]   extra_sel;
  logic [ADDR_W-1:0]      delay;
  logic signed [ADDR_W:0] diff;
  logic signed [ADDR_W:0] diff_wrapped;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   mute;

  // Tap address: clamp the offset, then wr_ptr - D modulo the buffer depth.
  always_comb begin
    extra_sel    = (extra_q < EXTRA_MAX) ? extra_q : EXTRA_MAX;
    delay        = AVG_D + ADDR_W'(extra_sel);
    diff         = $signed({1'b0, wr_ptr}) - $signed({1'b0, delay});
    diff_wrapped = diff;
    if (diff < 0) begin
      diff_wrapped = diff + DEPTH_S;
    end
    rd_addr = diff_wrapped[ADDR_W-1:0];
  end

`ifdef DELAY_PRIME_MUTE_EN
  localparam int PRIME_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PRIME_W-1:0] PRIME_FULL = PRIME_W'(BUF_DEPTH);

  logic [PRIME_W-1:0] prime_cnt;

  // Count completed schedules; the count is taken after the mute decision
  // so the first BUF_DEPTH outputs are all muted.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prime_cnt <= '0;
    end else if (state == S_CAPTURE && prime_cnt != PRIME_FULL) begin
      prime_cnt <= prime_cnt + 1'b1;
    end
  end

  assign mute = (prime_cnt != PRIME_FULL);
`else
  assign mute = 1'b0;
`endif

  // Schedule FSM; all RAM and mixer outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state               <= S_IDLE;
      wr_ptr              <= '0;
      extra_q             <= '0;
      ramAddr_o           <= '0;
      ramWrData_o         <= '0;
      ramWrEn_o           <= 1'b0;
      pktDelayed_o        <= '0;
      pktDelayedChanged_o <= 1'b0;
      busy_o              <= 1'b0;
      overrun_o           <= 1'b0;
    end else begin
      pktDelayedChanged_o <= 1'b0;
      if (pktChanged_i && state != S_IDLE) begin
        overrun_o <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (pktChanged_i) begin
            ramWrEn_o   <= 1'b1;
            ramAddr_o   <= wr_ptr;
            ramWrData_o <= pkt_i;
            extra_q     <= extraDelay_i;
            busy_o      <= 1'b1;
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          ramWrEn_o <= 1'b0;
          ramAddr_o <= rd_addr;
          state     <= S_READ;
        end
        S_READ: begin
          wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
          state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          pktDelayed_o        <= mute ? '0 : ramRdData_i;
          pktDelayedChanged_o <= 1'b1;
          busy_o              <= 1'b0;
          state               <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_delay_ram_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_ram_scheduler
// Description : Self-checking bench for delay_ram_scheduler with a
//               behavioural single-port RAM (registered read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_ram_scheduler;

  localparam int PW    = 16;
  localparam int DEPTH = 4410;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [PW-1:0] pkt_i = '0;
  logic          pktChanged_i = 1'b0;
  logic [PW-1:0] extraDelay_i = '0;
  logic [AW-1:0] ramAddr_o;
  logic [PW-1:0] ramWrData_o;
  logic          ramWrEn_o;
  logic [PW-1:0] ramRdData_i;
  logic [PW-1:0] pktDelayed_o;
  logic          pktDelayedChanged_o;
  logic          busy_o;
  logic          overrun_o;

  int tests = 0;
  int fails = 0;

  delay_ram_scheduler #(
    .PKT_WIDTH(PW), .BUF_DEPTH(DEPTH), .AVG_DELAY(882)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .pkt_i(pkt_i), .pktChanged_i(pktChanged_i),
    .extraDelay_i(extraDelay_i), .ramAddr_o(ramAddr_o), .ramWrData_o(ramWrData_o),
    .ramWrEn_o(ramWrEn_o), .ramRdData_i(ramRdData_i), .pktDelayed_o(pktDelayed_o),
    .pktDelayedChanged_o(pktDelayedChanged_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: never-written slots return a recognisable pattern.
  logic [PW-1:0] mem [DEPTH];
  bit            written [DEPTH];
  always @(posedge clk) begin
    if (int'(ramAddr_o) < DEPTH) begin
      if (ramWrEn_o) begin
        mem[ramAddr_o]     <= ramWrData_o;
        written[ramAddr_o] <= 1'b1;
      end
      ramRdData_i <= written[ramAddr_o] ? mem[ramAddr_o] : (16'h5A00 ^ PW'(ramAddr_o));
    end else begin
      ramRdData_i <= 16'hDEAD;
    end
  end

  typedef struct {
    logic [PW-1:0] pkt;
    logic [PW-1:0] extra;
    int            wa;
    int            ra;
  } vec_t;

  typedef struct {
    logic          wen1;
    int            wa;
    logic [PW-1:0] wd;
    logic          bsy1;
    logic          wen2;
    int            ra;
    logic          stb3;
    logic          stb4;
    logic [PW-1:0] dly;
    logic          bsy4;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"},  32'(ramAddr_o), 0);
    chk({tag, "_wdata"}, 32'(ramWrData_o), 0);
    chk({tag, "_wen"},   32'(ramWrEn_o), 0);
    chk({tag, "_dly"},   32'(pktDelayed_o), 0);
    chk({tag, "_stb"},   32'(pktDelayedChanged_o), 0);
    chk({tag, "_busy"},  32'(busy_o), 0);
    chk({tag, "_ovr"},   32'(overrun_o), 0);
  endtask

  // One strobe in cycle N, observe N+1..N+4; returns in cycle N+4.
  task automatic run_sched(input logic [PW-1:0] p, input logic [PW-1:0] e, output obs_t o);
    pkt_i = p;
    extraDelay_i = e;
    pktChanged_i = 1'b1;
    tick();
    pktChanged_i = 1'b0;
    o.wen1 = ramWrEn_o;
    o.wa   = int'(ramAddr_o);
    o.wd   = ramWrData_o;
    o.bsy1 = busy_o;
    tick();
    o.wen2 = ramWrEn_o;
    o.ra   = int'(ramAddr_o);
    tick();
    o.stb3 = pktDelayedChanged_o;
    tick();
    o.stb4 = pktDelayedChanged_o;
    o.dly  = pktDelayed_o;
    o.bsy4 = busy_o;
  endtask

  initial begin
    vec_t vecs [8];
    obs_t o;
    int   wr_cnt;
    int   stb_cnt;
    int   ramp_err;
    logic [PW-1:0] exp_d;

    vecs[0] = '{16'h1234, 16'h0000, 0, 3528};
    vecs[1] = '{16'h1111, 16'h0064, 1, 3429};
    vecs[2] = '{16'h2222, 16'hFFFF, 2, 3};
    vecs[3] = '{16'h3333, 16'h0DC7, 3, 4};
    vecs[4] = '{16'h4444, 16'h0DC8, 4, 5};
    vecs[5] = '{16'h5555, 16'h0DC6, 5, 7};
    vecs[6] = '{16'h6666, 16'h8000, 6, 7};
    vecs[7] = '{16'h7777, 16'h0007, 7, 3528};

    // Reset state
    repeat (3) tick();
    check_zero("rst");
    reset_i = 1'b0;
    tick();

    // Table: schedule timing, clamp and tap address arithmetic
    for (int i = 0; i < 8; i++) begin
      run_sched(vecs[i].pkt, vecs[i].extra, o);
      chk($sformatf("v%0d_wen1", i), 32'(o.wen1), 1);
      chk($sformatf("v%0d_waddr", i), 32'(o.wa), 32'(vecs[i].wa));
      chk($sformatf("v%0d_wdata", i), 32'(o.wd), 32'(vecs[i].pkt));
      chk($sformatf("v%0d_busy1", i), 32'(o.bsy1), 1);
      chk($sformatf("v%0d_wen2", i), 32'(o.wen2), 0);
      chk($sformatf("v%0d_raddr", i), 32'(o.ra), 32'(vecs[i].ra));
      chk($sformatf("v%0d_stb3", i), 32'(o.stb3), 0);
      chk($sformatf("v%0d_stb4", i), 32'(o.stb4), 1);
      chk($sformatf("v%0d_dly", i), 32'(o.dly), 32'(16'h5A00 ^ PW'(vecs[i].ra)));
      chk($sformatf("v%0d_busy4", i), 32'(o.bsy4), 0);
    end
    chk("table_ovr", 32'(overrun_o), 0);

    // Overrun: strobes at N and N+2
    wr_cnt = 0;
    stb_cnt = 0;
    pkt_i = 16'hAAAA;
    pktChanged_i = 1'b1;
    tick();
    pktChanged_i = 1'b0;
    wr_cnt += int'(ramWrEn_o);
    stb_cnt += int'(pktDelayedChanged_o);
    chk("ovr_n1", 32'(overrun_o), 0);
    tick();
    wr_cnt += int'(ramWrEn_o);
    stb_cnt += int'(pktDelayedChanged_o);
    pkt_i = 16'hBBBB;
    pktChanged_i = 1'b1;
    tick();
    pktChanged_i = 1'b0;
    chk("ovr_n3", 32'(overrun_o), 1);
    for (int c = 0; c < 7; c++) begin
      wr_cnt += int'(ramWrEn_o);
      stb_cnt += int'(pktDelayedChanged_o);
      tick();
    end
    chk("ovr_wr_pulses", 32'(wr_cnt), 1);
    chk("ovr_out_strobes", 32'(stb_cnt), 1);
    chk("ovr_sticky", 32'(overrun_o), 1);
    do_reset();
    check_zero("ovr_clr");

    // Mid-schedule reset
    run_sched(16'h0101, 16'h0000, o);
    chk("mid_pre_waddr", 32'(o.wa), 0);
    pkt_i = 16'h0202;
    pktChanged_i = 1'b1;
    tick();
    pktChanged_i = 1'b0;
    chk("mid_n1_waddr", 32'(ramAddr_o), 1);
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_zero("mid_n3");
    stb_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      stb_cnt += int'(pktDelayedChanged_o);
    end
    chk("mid_no_strobe", 32'(stb_cnt), 0);
    run_sched(16'h0303, 16'h0000, o);
    chk("mid_next_waddr", 32'(o.wa), 0);

    // Back-to-back: strobes at N and N+4
    do_reset();
    run_sched(16'hC001, 16'h0000, o);
    chk("b2b_a_waddr", 32'(o.wa), 0);
    chk("b2b_a_wdata", 32'(o.wd), 32'(16'hC001));
    chk("b2b_a_stb", 32'(o.stb4), 1);
    run_sched(16'hC002, 16'h0000, o);
    chk("b2b_b_wen", 32'(o.wen1), 1);
    chk("b2b_b_waddr", 32'(o.wa), 1);
    chk("b2b_b_wdata", 32'(o.wd), 32'(16'hC002));
    chk("b2b_b_stb", 32'(o.stb4), 1);
    chk("b2b_ovr", 32'(overrun_o), 0);

    // Ramp through the full buffer; last one uses max offset (tap wraps to 0)
    do_reset();
    ramp_err = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      run_sched(PW'(k), (k == DEPTH) ? 16'hFFFF : 16'h0000, o);
      if (k > 882) begin
        exp_d = (k == DEPTH) ? 16'd1 : PW'(k - 882);
        if (o.dly !== exp_d || o.stb4 !== 1'b1) begin
          if (ramp_err == 0) begin
            chk($sformatf("ramp_k%0d", k), 32'(o.dly), 32'(exp_d));
          end
          ramp_err++;
        end
      end
    end
    chk("ramp_errors", 32'(ramp_err), 0);
    chk("wrap_raddr_top", 32'(o.ra), 0);
    run_sched(16'hF00D, 16'hFFFF, o);
    chk("wrap_waddr", 32'(o.wa), 0);
    chk("wrap_raddr", 32'(o.ra), 1);
    chk("wrap_dly", 32'(o.dly), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
